// File: rtl/tl_rr_arbiter.sv
// Egress arbiter: drains four TL class FIFOs round-robin into one registered stream and
// keeps per-class delivered-word counters. Define TL_ARB_PRIORITY_EN for strict class-0 priority.
module tl_rr_cnt #(
    parameter int CW = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] cnt
);
    logic [CW-1:0] cnt_q, cnt_d;

    // Clear beats increment; saturate instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (inc && cnt_q != {CW{1'b1}})
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;
endmodule

module tl_rr_arbiter #(
    parameter int DW = 12,
    parameter int CW = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          init,
    input  logic [DW-1:0] data_in0,
    input  logic [DW-1:0] data_in1,
    input  logic [DW-1:0] data_in2,
    input  logic [DW-1:0] data_in3,
    input  logic          empty0,
    input  logic          empty1,
    input  logic          empty2,
    input  logic          empty3,
    output logic          pop_out0,
    output logic          pop_out1,
    output logic          pop_out2,
    output logic          pop_out3,
    input  logic          stall,
    output logic [DW-1:0] data_out,
    output logic          valid_out,
    output logic [1:0]    class_out,
    input  logic          req,
    input  logic [1:0]    idx,
    output logic [CW-1:0] contador,
    output logic          valid,
    output logic          idle
);
    localparam int NCLS = 4;

    typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_ACTIVE} state_e;

    state_e                   state_q, state_d;
    logic [1:0]               last_q, last_d, sel_q, sel_d, class_out_q, class_out_d;
    logic                     inflight_q, inflight_d, valid_out_q, valid_out_d;
    logic                     valid_q, valid_d;
    logic [DW-1:0]            data_out_q, data_out_d;
    logic [CW-1:0]            contador_q, contador_d;
    logic [NCLS-1:0][DW-1:0]  din;
    logic [NCLS-1:0][CW-1:0]  cnt;
    logic [NCLS-1:0]          empty, pop, inc;
    logic                     all_empty, grant_vld, go;
    logic [1:0]               grant;

    assign din       = {data_in3, data_in2, data_in1, data_in0};
    assign empty     = {empty3, empty2, empty1, empty0};
    assign all_empty = &empty;

`ifdef TL_ARB_PRIORITY_EN
    // Rotation covers classes 1..3 only; class 0 bypasses it.
    function automatic logic [1:0] rr_cand(input logic [1:0] last, input int step);
        return 2'((int'(last) + step - 1) % 3 + 1);
    endfunction
`else
    function automatic logic [1:0] rr_cand(input logic [1:0] last, input int step);
        return 2'(int'(last) + step);
    endfunction
`endif

    always_comb begin
        grant_vld = 1'b0;
        grant     = 2'd0;
`ifdef TL_ARB_PRIORITY_EN
        if (!empty[0]) begin
            grant_vld = 1'b1;
            grant     = 2'd0;
        end
        for (int s = 1; s <= 3; s++) begin
`else
        for (int s = 1; s <= NCLS; s++) begin
`endif
            if (!grant_vld && !empty[rr_cand(last_q, s)]) begin
                grant_vld = 1'b1;
                grant     = rr_cand(last_q, s);
            end
        end
    end

    assign go = (state_q == ST_ACTIVE) && !stall && !init && grant_vld;

    always_comb begin
        pop        = '0;
        last_d     = last_q;
        sel_d      = sel_q;
        inflight_d = go;
        if (go) begin
            pop[grant] = 1'b1;
            sel_d      = grant;
`ifdef TL_ARB_PRIORITY_EN
            if (grant != 2'd0) last_d = grant;
`else
            last_d = grant;
`endif
        end
        if (init) last_d = 2'd3;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT:   if (!init) state_d = ST_IDLE;
            ST_IDLE:   if (!all_empty) state_d = ST_ACTIVE;
            ST_ACTIVE: if (all_empty && !inflight_q) state_d = ST_IDLE;
            default:   state_d = ST_INIT;
        endcase
        if (init) state_d = ST_INIT;
    end

    // Popped words are delivered regardless of init/stall; only reset drops them.
    always_comb begin
        valid_out_d = inflight_q;
        data_out_d  = data_out_q;
        class_out_d = class_out_q;
        if (inflight_q) begin
            data_out_d  = din[sel_q];
            class_out_d = sel_q;
        end
        valid_d    = req;
        contador_d = contador_q;
        if (req) contador_d = init ? '0 : cnt[idx];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_INIT;
            last_q      <= 2'd3;
            sel_q       <= 2'd0;
            inflight_q  <= 1'b0;
            valid_out_q <= 1'b0;
            data_out_q  <= '0;
            class_out_q <= 2'd0;
            valid_q     <= 1'b0;
            contador_q  <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            sel_q       <= sel_d;
            inflight_q  <= inflight_d;
            valid_out_q <= valid_out_d;
            data_out_q  <= data_out_d;
            class_out_q <= class_out_d;
            valid_q     <= valid_d;
            contador_q  <= contador_d;
        end
    end

    for (genvar k = 0; k < NCLS; k++) begin : g_cnt
        assign inc[k] = valid_out_q && (class_out_q == 2'(k));
        tl_rr_cnt #(.CW(CW)) u_cnt (
            .clk   (clk),
            .reset (reset),
            .clr   (init),
            .inc   (inc[k]),
            .cnt   (cnt[k])
        );
    end

    assign {pop_out3, pop_out2, pop_out1, pop_out0} = pop;
    assign data_out  = data_out_q;
    assign valid_out = valid_out_q;
    assign class_out = class_out_q;
    assign contador  = contador_q;
    assign valid     = valid_q;
    assign idle      = (state_q == ST_IDLE) && all_empty && !inflight_q;
endmodule

// File: doc/tl_rr_arbiter.md
# tl_rr_arbiter

Downstream egress stage of the PCIe transaction-layer model. It drains the four class FIFOs (classes 0–3) of the transaction layer and merges them into a single 12-bit stream toward the data-link layer. Draining uses a round-robin scheduler with downstream back-pressure. The block keeps a per-class forwarded-word counter that can be read on request, in the same way as the transaction layer's `contador` read port.

## Interface
Parameters:
- `DW`, 12, word width of FIFO and output data.
- `CW`, 5, width of each per-class counter.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state immediately.
- `init`  in  1  synchronous re-initialisation: clears counters and scheduler, suppresses pops.
- `data_in0..data_in3`  in  DW  FIFO read data; valid the cycle after the matching pop.
- `empty0..empty3`  in  1  FIFO empty flags.
- `pop_out0..pop_out3`  out  1  FIFO pop strobes; combinational, at most one high per cycle.
- `stall`  in  1  downstream almost-full; no new pop while high.
- `data_out`  out  DW  merged output word, registered.
- `valid_out`  out  1  `data_out` valid this cycle.
- `class_out`  out  2  source class of `data_out`.
- `req`  in  1  counter read request.
- `idx`  in  2  class counter to read.
- `contador`  out  CW  counter read data, registered.
- `valid`  out  1  `contador` valid.
- `idle`  out  1  all FIFOs empty, nothing in flight, FSM in IDLE.

## Operation
- FSM states:
  - INIT: entered on reset, or from any state while `init`=1.
  - IDLE.
  - ACTIVE.
- Transitions:
  - INIT → IDLE when `init`=0.
  - IDLE → ACTIVE when any `emptyK`=0.
  - ACTIVE → IDLE when all `emptyK`=1 and no word is in flight.
- Scheduler:
  - A 2-bit pointer `last` is reset to 3, so the first grant goes to class 0.
  - In ACTIVE with `stall`=0, the first non-empty class searched from `last+1` mod 4 is granted.
  - The granted `pop_outK` is asserted and `last` is set to K.
  - With no eligible class, no pop is issued and `last` holds.
- Pops are never issued in INIT or IDLE, or while `stall`=1.
- Popped class is registered as `sel_q` and a flag as `inflight_q`.
  - The following cycle, `data_in[sel_q]` is captured into `data_out`.
  - `class_out` is set to `sel_q` and `valid_out` to 1.
- Words already popped are always delivered, even if `stall` rises or `init` is asserted. The downstream threshold must absorb 2 words.
- Counters:
  - Counter K increments when a class-K word is delivered (`valid_out` registered high).
  - Counters saturate at 31 and do not wrap.
  - `init`=1 clears all counters; clear wins over a simultaneous increment.
- Counter read:
  - `req`=1 with `idx` in cycle N gives `contador`=counter[idx] and `valid`=1 in cycle N+1.
  - The returned value is the pre-increment value if an increment coincides.
  - With `req`=0, `valid`=0 and `contador` holds.
- `idle`=1 only in IDLE state.

## Timing
- Reset values: `data_out`=0, `class_out`=0, `valid_out`=0, `contador`=0, `valid`=0, `idle`=0, all pops 0, counters 0, `last`=3, FSM=INIT.
- Pop-to-output latency:
  - Pop in cycle N; the FIFO drives data in N+1.
  - `data_out`/`valid_out` are high in N+2 for exactly one cycle.
- Throughput is one word per cycle. Back-to-back pops are allowed; the empty flag must reflect a pop by the next cycle.
- `stall` is sampled combinationally. `stall`=1 in cycle N blocks the pop in N only.
- Reset asserted mid-transfer drops the in-flight word; no `valid_out` follows.
- `init` mid-transfer:
  - The in-flight word is still output.
  - It is not counted if `init` is high during its delivery cycle.
- Simultaneous `req` and `init`: the read returns 0.

## Configuration
- `TL_ARB_PRIORITY_EN` defined:
  - Class 0 has strict priority: granted whenever `empty0`=0 and `stall`=0.
  - Classes 1–3 round-robin among themselves, with `last` tracking only those classes.
- Undefined: pure 4-way round-robin as described above.

## Test plan
- Reset, then `init` pulse; FIFO0..3 hold 2 words each (values 0x100+K*0x10+i); `stall`=0 → output class order 0,1,2,3,0,1,2,3; first `valid_out` 2 cycles after first pop; `idle`=1 after last word.
- Only FIFO2 non-empty with 3 words → `pop_out2` high 3 consecutive cycles; 3 back-to-back `valid_out` with `class_out`=2; no other pops.
- `stall`=1 for 4 cycles mid-stream → no pops during those cycles; the 2 in-flight words are still output; resumes at the next class in round-robin order.
- Feed 40 words on class 1, then `req`=1 with `idx`=1 → `contador`=31 and `valid`=1 next cycle; `idx`=0 → 0.
- Drop `reset` while a word is in flight → `valid_out`=0 immediately, all outputs at reset values; after `init`, first grant is class 0.
- With `TL_ARB_PRIORITY_EN` and FIFO0 refilled continuously → only class 0 is served while FIFO0 is non-empty; classes 1–3 are served in rotation once FIFO0 empties.
